yuv422_unpack: RTL and testbench

Byte-serial YCbCr 4:2:2 to parallel 4:4:4 unpacker. Sits directly upstream of the YCbCr-to-RGB converter: it takes the 8-bit interleaved stream from the camera/decoder interface and presents one full Y/Cb/Cr triple per pixel on `out_y`/`out_cb`/`out_cr`. It also checks line length and flags malformed lines.

---
 rtl/img_pkg.sv | 30 +++
 rtl/yuv422_unpack.sv | 163 ++++++++++++++++
 tb/tb_yuv422_unpack.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// Shared image-pipeline types: byte-phase enum, chroma byte-order constants and
// the YCbCr pixel triple also consumed by the downstream RGB converter.
package img_pkg;

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_e;

  localparam int ORDER_UYVY = 0;
  localparam int ORDER_YUYV = 1;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } ycc_pix_t;

  function automatic ycc_pix_t mk_pix(input logic [7:0] y, input logic [7:0] cb,
                                      input logic [7:0] cr);
    ycc_pix_t p;
    p.y  = y;
    p.cb = cb;
    p.cr = cr;
    return p;
  endfunction

endpackage

// File: rtl/yuv422_unpack.sv
// Byte-serial YCbCr 4:2:2 to parallel 4:4:4 unpacker with chroma duplication
// and per-line length checking (sticky line_err).
module yuv422_unpack
  import img_pkg::*;
#(
  parameter int ORDER    = ORDER_UYVY,
  parameter int H_ACTIVE = 640,
  parameter int CW       = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_de,
  input  logic [7:0] in_data,
  output logic       out_valid,
  output logic       out_sol,
  output logic [7:0] out_y,
  output logic [7:0] out_cb,
  output logic [7:0] out_cr,
  output logic       line_err,
  output logic [1:0] dbg_phase
);

  // Stream contract: in_de qualifies in_data every cycle with no ready; out_valid
  // is a one-cycle strobe with no backpressure, the consumer takes every pixel.
  localparam bit IS_UYVY = (ORDER == ORDER_UYVY);

  phase_e        phase_q, phase_d;
  logic [7:0]    cb_h_q, cb_h_d;
  logic [7:0]    y0_h_q, y0_h_d;
  logic [7:0]    cr_h_q, cr_h_d;
  logic [7:0]    y1_h_q, y1_h_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] pix_cnt_q, pix_cnt_d;
  logic          de_prev_q, de_prev_d;
  logic          line_err_q, line_err_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sol_q, out_sol_d;
  ycc_pix_t      out_pix_q, out_pix_d;

  logic          emit;
  ycc_pix_t      emit_pix;
  logic          de_fall;
  logic [CW:0]   line_n;

  always_comb begin
    phase_d     = phase_q;
    cb_h_d      = cb_h_q;
    y0_h_d      = y0_h_q;
    cr_h_d      = cr_h_q;
    y1_h_d      = y1_h_q;
    pend_d      = 1'b0;
    pix_cnt_d   = pix_cnt_q;
    de_prev_d   = in_de;
    line_err_d  = line_err_q;
    out_valid_d = 1'b0;
    out_sol_d   = 1'b0;
    out_pix_d   = out_pix_q;
    emit        = 1'b0;
    // Default candidate is the YUYV pixel 1 deferred from the previous Cr byte.
    emit_pix    = mk_pix(y1_h_q, cb_h_q, cr_h_q);
    de_fall     = de_prev_q & ~in_de;
    line_n      = {1'b0, pix_cnt_q} + {{CW{1'b0}}, pend_q};

    if (pend_q) begin
      emit = 1'b1;
    end

    if (!in_de) begin
      phase_d = P0;
    end else begin
      case (phase_q)
        P0: begin
          phase_d = P1;
          if (IS_UYVY) cb_h_d = in_data;
          else         y0_h_d = in_data;
        end
        P1: begin
          phase_d = P2;
          if (IS_UYVY) y0_h_d = in_data;
          else         cb_h_d = in_data;
        end
        P2: begin
          phase_d = P3;
          if (IS_UYVY) begin
            cr_h_d   = in_data;
            emit     = 1'b1;
            emit_pix = mk_pix(y0_h_q, cb_h_q, in_data);
          end else begin
            y1_h_d = in_data;
          end
        end
        P3: begin
          phase_d = P0;
          emit    = 1'b1;
          if (IS_UYVY) begin
            emit_pix = mk_pix(in_data, cb_h_q, cr_h_q);
          end else begin
            cr_h_d   = in_data;
            pend_d   = 1'b1;
            emit_pix = mk_pix(y0_h_q, cb_h_q, in_data);
          end
        end
        default: phase_d = P0;
      endcase
    end

    if (emit) begin
      out_valid_d = 1'b1;
      out_sol_d   = (pix_cnt_q == '0);
      out_pix_d   = emit_pix;
      if (pix_cnt_q != '1) begin
        pix_cnt_d = pix_cnt_q + CW'(1);
      end
    end

    // End of line: the deferred YUYV pixel 1 still counts toward the length.
    if (de_fall) begin
      if ((line_n != (CW + 1)'(H_ACTIVE)) || (phase_q != P0)) begin
        line_err_d = 1'b1;
      end
      pix_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= P0;
      cb_h_q      <= '0;
      y0_h_q      <= '0;
      cr_h_q      <= '0;
      y1_h_q      <= '0;
      pend_q      <= 1'b0;
      pix_cnt_q   <= '0;
      de_prev_q   <= 1'b0;
      line_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sol_q   <= 1'b0;
      out_pix_q   <= '0;
    end else begin
      phase_q     <= phase_d;
      cb_h_q      <= cb_h_d;
      y0_h_q      <= y0_h_d;
      cr_h_q      <= cr_h_d;
      y1_h_q      <= y1_h_d;
      pend_q      <= pend_d;
      pix_cnt_q   <= pix_cnt_d;
      de_prev_q   <= de_prev_d;
      line_err_q  <= line_err_d;
      out_valid_q <= out_valid_d;
      out_sol_q   <= out_sol_d;
      out_pix_q   <= out_pix_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sol   = out_sol_q;
  assign out_y     = out_pix_q.y;
  assign out_cb    = out_pix_q.cb;
  assign out_cr    = out_pix_q.cr;
  assign line_err  = line_err_q;
  assign dbg_phase = phase_q;

endmodule

// File: tb/tb_yuv422_unpack.sv
// Bench for yuv422_unpack: three configurations share one byte stream and are
// checked every cycle against a pair-level model, plus literal pixel tables.
module tb_yuv422_unpack;
  import img_pkg::*;

  localparam int ND = 3;
  localparam int ORD  [ND] = '{0, 1, 0};
  localparam int HACT [ND] = '{4, 4, 8};

  typedef struct {
    bit         v;
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    bit         sol;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    bit         sol;
  } cap_t;

  // ---------------- clock / reset / DUTs ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       in_de;
  logic [7:0] in_data;
  logic       ov   [ND];
  logic       os   [ND];
  logic       le_o [ND];
  logic [7:0] oy   [ND];
  logic [7:0] ocb  [ND];
  logic [7:0] ocr  [ND];
  logic [1:0] dph  [ND];

  always #5 clk = ~clk;

  yuv422_unpack #(.ORDER(0), .H_ACTIVE(4), .CW(12)) u0 (
    .clk(clk), .rst(rst), .in_de(in_de), .in_data(in_data),
    .out_valid(ov[0]), .out_sol(os[0]), .out_y(oy[0]), .out_cb(ocb[0]), .out_cr(ocr[0]),
    .line_err(le_o[0]), .dbg_phase(dph[0]));

  yuv422_unpack #(.ORDER(1), .H_ACTIVE(4), .CW(12)) u1 (
    .clk(clk), .rst(rst), .in_de(in_de), .in_data(in_data),
    .out_valid(ov[1]), .out_sol(os[1]), .out_y(oy[1]), .out_cb(ocb[1]), .out_cr(ocr[1]),
    .line_err(le_o[1]), .dbg_phase(dph[1]));

  yuv422_unpack #(.ORDER(0), .H_ACTIVE(8), .CW(4)) u2 (
    .clk(clk), .rst(rst), .in_de(in_de), .in_data(in_data),
    .out_valid(ov[2]), .out_sol(os[2]), .out_y(oy[2]), .out_cb(ocb[2]), .out_cr(ocr[2]),
    .line_err(le_o[2]), .dbg_phase(dph[2]));

  // ---------------- bookkeeping ----------------
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   fall_cyc = 0;
  cap_t cap0[$];
  cap_t cap1[$];
  cap_t cap2[$];
  int   le_rise [ND];
  bit   le_prev [ND];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_pix(input string nm, input cap_t c, input logic [7:0] y,
                         input logic [7:0] cb, input logic [7:0] cr, input bit sol);
    chk({nm, " y"}, c.y, y);
    chk({nm, " cb"}, c.cb, cb);
    chk({nm, " cr"}, c.cr, cr);
    chk({nm, " sol"}, c.sol, sol);
  endtask

  function automatic int sol_count(input cap_t q[$]);
    int n = 0;
    foreach (q[k]) if (q[k].sol) n++;
    return n;
  endfunction

  // ---------------- pair-level model ----------------
  exp_t       e_now  [ND];
  exp_t       e_pend [ND];
  logic [7:0] pb     [ND][4];
  int         pn     [ND];
  int         lp     [ND];
  bit         le_m   [ND];
  bit         prev_de = 1'b0;

  task automatic m_emit(input int i, input logic [7:0] y, input logic [7:0] cb,
                        input logic [7:0] cr);
    e_now[i].v   = 1'b1;
    e_now[i].y   = y;
    e_now[i].cb  = cb;
    e_now[i].cr  = cr;
    e_now[i].sol = (lp[i] == 0);
    lp[i]++;
  endtask

  initial begin
    for (int i = 0; i < ND; i++) begin
      e_now[i].v = 1'b0; e_pend[i].v = 1'b0; pn[i] = 0; lp[i] = 0; le_m[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < ND; i++) begin
        e_now[i].v = 1'b0;
        if (rst) begin
          e_pend[i].v = 1'b0; pn[i] = 0; lp[i] = 0; le_m[i] = 1'b0;
        end else begin
          if (e_pend[i].v) begin
            m_emit(i, e_pend[i].y, e_pend[i].cb, e_pend[i].cr);
            e_pend[i].v = 1'b0;
          end
          if (in_de) begin
            pb[i][pn[i]] = in_data;
            pn[i]++;
            // Pair bytes in arrival order: UYVY = Cb Y0 Cr Y1, YUYV = Y0 Cb Y1 Cr.
            if (ORD[i] == 0 && pn[i] == 3) m_emit(i, pb[i][1], pb[i][0], pb[i][2]);
            if (pn[i] == 4) begin
              if (ORD[i] == 0) begin
                m_emit(i, pb[i][3], pb[i][0], pb[i][2]);
              end else begin
                m_emit(i, pb[i][0], pb[i][1], pb[i][3]);
                e_pend[i].v  = 1'b1;
                e_pend[i].y  = pb[i][2];
                e_pend[i].cb = pb[i][1];
                e_pend[i].cr = pb[i][3];
              end
              pn[i] = 0;
            end
          end else begin
            if (prev_de && (lp[i] != HACT[i] || pn[i] != 0)) le_m[i] = 1'b1;
            lp[i] = 0;
            pn[i] = 0;
          end
        end
      end
      prev_de = rst ? 1'b0 : in_de;
    end
  end

  // ---------------- per-cycle compare + capture ----------------
  initial begin
    for (int i = 0; i < ND; i++) begin
      le_rise[i] = -1; le_prev[i] = 1'b0;
    end
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int i = 0; i < ND; i++) begin
        cap_t c;
        chk($sformatf("u%0d out_valid", i), ov[i], e_now[i].v);
        if (e_now[i].v && ov[i] === 1'b1) begin
          chk($sformatf("u%0d out_y", i), oy[i], e_now[i].y);
          chk($sformatf("u%0d out_cb", i), ocb[i], e_now[i].cb);
          chk($sformatf("u%0d out_cr", i), ocr[i], e_now[i].cr);
          chk($sformatf("u%0d out_sol", i), os[i], e_now[i].sol);
        end
        chk($sformatf("u%0d line_err", i), le_o[i], le_m[i]);
        if (le_o[i] === 1'b1 && !le_prev[i]) le_rise[i] = cyc;
        le_prev[i] = (le_o[i] === 1'b1);
        if (ov[i] === 1'b1) begin
          c.cyc = cyc; c.y = oy[i]; c.cb = ocb[i]; c.cr = ocr[i]; c.sol = os[i];
          case (i)
            0:       cap0.push_back(c);
            1:       cap1.push_back(c);
            default: cap2.push_back(c);
          endcase
        end
      end
    end
  end

  // ---------------- driver tasks (entered and left at a falling edge) ----------------
  task automatic drive_line(input int base, input int step, input int n);
    for (int k = 0; k < n; k++) begin
      in_de   = 1'b1;
      in_data = 8'(base + step * k);
      @(negedge clk);
    end
    in_de    = 1'b0;
    fall_cyc = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_caps();
    cap0.delete(); cap1.delete(); cap2.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_de = 1'b0;
    idle(2);
    for (int i = 0; i < ND; i++) chk($sformatf("u%0d line_err in reset", i), le_o[i], 0);
    rst = 1'b0;
    idle(1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1; in_de = 1'b0; in_data = 8'h00;
    idle(3);
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("u%0d reset valid", i), ov[i], 0);
      chk($sformatf("u%0d reset sol", i), os[i], 0);
      chk($sformatf("u%0d reset y", i), oy[i], 0);
      chk($sformatf("u%0d reset cb", i), ocb[i], 0);
      chk($sformatf("u%0d reset cr", i), ocr[i], 0);
      chk($sformatf("u%0d reset line_err", i), le_o[i], 0);
      chk($sformatf("u%0d reset phase", i), dph[i], 0);
    end
    rst = 1'b0;
    idle(1);

    // Bytes 10..80 seen as UYVY by u0 and YUYV by u1.
    clear_caps();
    drive_line(10, 10, 8);
    idle(3);
    chk("t1 uyvy count", cap0.size(), 4);
    if (cap0.size() == 4) begin
      chk_pix("t1 uyvy p0", cap0[0], 20, 10, 30, 1);
      chk_pix("t1 uyvy p1", cap0[1], 40, 10, 30, 0);
      chk_pix("t1 uyvy p2", cap0[2], 60, 50, 70, 0);
      chk_pix("t1 uyvy p3", cap0[3], 80, 50, 70, 0);
      chk("t1 uyvy last cycle", cap0[3].cyc, fall_cyc - 1);
    end
    chk("t1 yuyv count", cap1.size(), 4);
    if (cap1.size() == 4) begin
      chk_pix("t1 yuyv p0", cap1[0], 10, 20, 40, 1);
      chk_pix("t1 yuyv p1", cap1[1], 30, 20, 40, 0);
      chk_pix("t1 yuyv p2", cap1[2], 50, 60, 80, 0);
      chk_pix("t1 yuyv p3", cap1[3], 70, 60, 80, 0);
      chk("t1 yuyv last cycle", cap1[3].cyc, fall_cyc);
    end
    chk("t1 uyvy line_err", le_o[0], 0);
    chk("t1 yuyv line_err", le_o[1], 0);
    chk("t1 short-for-8 line_err", le_o[2], 1);

    // in_de drops after 6 bytes: third pair discarded, error is sticky.
    clear_caps();
    drive_line(11, 11, 6);
    idle(2);
    chk("t2 gap count", cap0.size(), 2);
    if (cap0.size() == 2) begin
      chk_pix("t2 gap p0", cap0[0], 22, 11, 33, 1);
      chk_pix("t2 gap p1", cap0[1], 44, 11, 33, 0);
    end
    chk("t2 gap line_err", le_o[0], 1);
    clear_caps();
    drive_line(10, 10, 8);
    idle(2);
    chk("t2 good line count", cap0.size(), 4);
    chk("t2 line_err sticky", le_o[0], 1);
    do_reset();

    // Long line: 10 pixels against H_ACTIVE=8, nothing truncated.
    clear_caps();
    drive_line(1, 3, 20);
    idle(3);
    chk("t3 long count", cap2.size(), 10);
    chk("t3 long sol count", sol_count(cap2), 1);
    chk("t3 long line_err rise cycle", le_rise[2], fall_cyc);
    chk("t3 long h4 count", cap0.size(), 10);
    // 20 pixels on a 4-bit counter: the count must stick, not wrap to a second sol.
    clear_caps();
    drive_line(0, 1, 40);
    idle(2);
    chk("t3 sat count", cap2.size(), 20);
    chk("t3 sat sol count", sol_count(cap2), 1);
    do_reset();

    // Reset one cycle after the UYVY Cr byte; in_de stays high across it.
    clear_caps();
    in_de = 1'b1; in_data = 8'd1;
    idle(1);
    in_data = 8'd2;
    idle(1);
    in_data = 8'd3;
    idle(1);
    chk("t4 pre-reset valid", ov[0], 1);
    chk("t4 pre-reset y", oy[0], 2);
    chk("t4 pre-reset cb", ocb[0], 1);
    chk("t4 pre-reset cr", ocr[0], 3);
    rst = 1'b1; in_data = 8'd4;
    idle(1);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t4 u%0d post-reset valid", i), ov[i], 0);
      chk($sformatf("t4 u%0d post-reset y", i), oy[i], 0);
      chk($sformatf("t4 u%0d post-reset cb", i), ocb[i], 0);
      chk($sformatf("t4 u%0d post-reset cr", i), ocr[i], 0);
      chk($sformatf("t4 u%0d post-reset sol", i), os[i], 0);
    end
    rst = 1'b0;
    drive_line(100, 10, 8);
    idle(3);
    chk("t4 uyvy count", cap0.size(), 5);
    if (cap0.size() == 5) begin
      chk_pix("t4 uyvy p1", cap0[1], 110, 100, 120, 1);
      chk_pix("t4 uyvy p4", cap0[4], 170, 140, 160, 0);
    end
    chk("t4 yuyv count", cap1.size(), 4);
    chk("t4 uyvy line_err", le_o[0], 0);
    chk("t4 yuyv line_err", le_o[1], 0);
    do_reset();

    // Back-to-back lines separated by a single idle cycle.
    clear_caps();
    drive_line(5, 7, 8);
    idle(1);
    drive_line(9, 5, 8);
    idle(3);
    chk("t5 uyvy count", cap0.size(), 8);
    chk("t5 yuyv count", cap1.size(), 8);
    chk("t5 uyvy sol count", sol_count(cap0), 2);
    chk("t5 yuyv sol count", sol_count(cap1), 2);
    if (cap1.size() == 8) begin
      chk("t5 yuyv second sol", cap1[4].sol, 1);
      chk_pix("t5 yuyv line2 p0", cap1[4], 9, 14, 24, 1);
    end
    chk("t5 uyvy line_err", le_o[0], 0);
    chk("t5 yuyv line_err", le_o[1], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
